// File: rtl/supersaw_voice_alloc.sv
// Polyphonic voice allocator: scans all voices once per event, then commits a
// retrigger, free-voice or oldest-voice-steal assignment to pitch/note/gate state.
module supersaw_voice_alloc #(
  parameter int NUM_VOICES = 4,
  parameter int NOTE_W     = 7,
  parameter int PITCH_W    = 16,
  parameter int AGE_W      = 8
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          ev_valid,
  output logic                          ev_ready,
  input  logic                          ev_on,
  input  logic [NOTE_W-1:0]             ev_note,
  input  logic [PITCH_W-1:0]            ev_pitch,
  input  logic                          panic,
  output logic [NUM_VOICES*PITCH_W-1:0] voice_pitch,
  output logic [NUM_VOICES*NOTE_W-1:0]  voice_note,
  output logic [NUM_VOICES-1:0]         voice_gate,
  output logic                          steal_pulse
);

  localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_COMMIT} state_t;

  state_t               r_state, w_state_nxt;
  logic                 w_accept;

  logic [IDX_W-1:0]     r_idx;
  logic                 r_match_vld, r_free_vld, r_old_vld;
  logic [IDX_W-1:0]     r_match_idx, r_free_idx, r_old_idx;
  logic [AGE_W-1:0]     r_old_age;

  logic                 r_ev_on;
  logic [NOTE_W-1:0]    r_ev_note;
  logic [PITCH_W-1:0]   r_ev_pitch;

  logic [NUM_VOICES-1:0] r_gate;
  logic [NOTE_W-1:0]     r_note  [NUM_VOICES];
  logic [PITCH_W-1:0]    r_pitch [NUM_VOICES];
  logic [AGE_W-1:0]      r_age   [NUM_VOICES];
  logic                  r_steal;

  logic                 w_cur_gate;
  logic [NOTE_W-1:0]    w_cur_note;
  logic [AGE_W-1:0]     w_cur_age;
  logic                 w_tgt_vld;
  logic [IDX_W-1:0]     w_tgt_idx;
  logic                 w_steal;

  function automatic logic [AGE_W-1:0] age_inc_sat(input logic [AGE_W-1:0] a);
    if (a == {AGE_W{1'b1}}) return a;
    return a + AGE_W'(1);
  endfunction

  assign ev_ready = (r_state == S_IDLE) && !panic;

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (ev_valid && ev_ready) begin
          w_accept    = 1'b1;
          w_state_nxt = S_SCAN;
        end
      end
      S_SCAN:   if (r_idx == LAST_IDX) w_state_nxt = S_COMMIT;
      S_COMMIT: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
    if (panic) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Event fields are captured on accept so later ev_* changes cannot leak in.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_ev_on    <= ev_on;
      r_ev_note  <= ev_note;
      r_ev_pitch <= ev_pitch;
    end
  end

  assign w_cur_gate = r_gate[r_idx];
  assign w_cur_note = r_note[r_idx];
  assign w_cur_age  = r_age[r_idx];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_idx       <= '0;
      r_match_vld <= 1'b0;
      r_match_idx <= '0;
      r_free_vld  <= 1'b0;
      r_free_idx  <= '0;
      r_old_vld   <= 1'b0;
      r_old_idx   <= '0;
      r_old_age   <= '0;
    end else if (w_accept) begin
      r_idx       <= '0;
      r_match_vld <= 1'b0;
      r_free_vld  <= 1'b0;
      r_old_vld   <= 1'b0;
      r_old_age   <= '0;
    end else if (r_state == S_SCAN) begin
      r_idx <= r_idx + IDX_W'(1);
      if (w_cur_gate && (w_cur_note == r_ev_note)) begin
        r_match_vld <= 1'b1;
        r_match_idx <= r_idx;
      end
      if (!w_cur_gate && !r_free_vld) begin
        r_free_vld <= 1'b1;
        r_free_idx <= r_idx;
      end
      // Strict greater-than keeps the lowest index on equal ages.
      if (w_cur_gate && (!r_old_vld || (w_cur_age > r_old_age))) begin
        r_old_vld <= 1'b1;
        r_old_idx <= r_idx;
        r_old_age <= w_cur_age;
      end
    end
  end

  always_comb begin
    w_tgt_vld = 1'b0;
    w_tgt_idx = '0;
    w_steal   = 1'b0;
    if (r_ev_on) begin
      if (r_match_vld) begin
        w_tgt_vld = 1'b1;
        w_tgt_idx = r_match_idx;
      end else if (r_free_vld) begin
        w_tgt_vld = 1'b1;
        w_tgt_idx = r_free_idx;
      end else if (r_old_vld) begin
        w_tgt_vld = 1'b1;
        w_tgt_idx = r_old_idx;
        w_steal   = 1'b1;
      end
    end
  end

  // Commit stage: panic overrides any pending commit.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_gate  <= '0;
      r_steal <= 1'b0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        r_note[v]  <= '0;
        r_pitch[v] <= '0;
        r_age[v]   <= '0;
      end
    end else begin
      r_steal <= 1'b0;
      if (panic) begin
        r_gate <= '0;
        for (int v = 0; v < NUM_VOICES; v++) r_age[v] <= '0;
      end else if (r_state == S_COMMIT) begin
        if (r_ev_on) begin
          r_steal <= w_steal;
          for (int v = 0; v < NUM_VOICES; v++) begin
            if (w_tgt_vld && (IDX_W'(v) == w_tgt_idx)) begin
              r_gate[v]  <= 1'b1;
              r_note[v]  <= r_ev_note;
              r_pitch[v] <= r_ev_pitch;
              r_age[v]   <= '0;
            end else if (r_gate[v]) begin
              r_age[v] <= age_inc_sat(r_age[v]);
            end
          end
        end else if (r_match_vld) begin
          r_gate[r_match_idx] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    voice_pitch = '0;
    voice_note  = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      voice_pitch[v*PITCH_W +: PITCH_W] = r_pitch[v];
      voice_note[v*NOTE_W +: NOTE_W]    = r_note[v];
    end
  end

  assign voice_gate  = r_gate;
  assign steal_pulse = r_steal;

endmodule

// File: tb/tb_supersaw_voice_alloc.sv
// Self-checking bench for supersaw_voice_alloc: vector table plus hand-written
// panic, mid-scan reset and age-saturation sequences, scored against a voice model.
module tb_supersaw_voice_alloc;
  localparam int NV = 4;
  localparam int NW = 7;
  localparam int PW = 16;
  localparam int AW = 8;
  localparam int AGE_MAX = (1 << AW) - 1;

  logic              clk = 1'b0;
  logic              resetn;
  logic              ev_valid;
  logic              ev_ready;
  logic              ev_on;
  logic [NW-1:0]     ev_note;
  logic [PW-1:0]     ev_pitch;
  logic              panic;
  logic [NV*PW-1:0]  voice_pitch;
  logic [NV*NW-1:0]  voice_note;
  logic [NV-1:0]     voice_gate;
  logic              steal_pulse;

  always #5 clk = ~clk;

  supersaw_voice_alloc #(
    .NUM_VOICES(NV), .NOTE_W(NW), .PITCH_W(PW), .AGE_W(AW)
  ) dut (
    .clk(clk), .resetn(resetn), .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_on(ev_on), .ev_note(ev_note), .ev_pitch(ev_pitch), .panic(panic),
    .voice_pitch(voice_pitch), .voice_note(voice_note), .voice_gate(voice_gate),
    .steal_pulse(steal_pulse)
  );

  typedef struct {
    logic [NV*PW-1:0] pitch;
    logic [NV*NW-1:0] note;
    logic [NV-1:0]    gate;
    logic             steal;
  } exp_t;

  typedef struct {
    logic          rst_before;
    logic          on;
    logic [NW-1:0] note;
    logic [PW-1:0] pitch;
    logic [NV-1:0] exp_gate;
    logic          exp_steal;
    logic [PW-1:0] exp_p0;
  } vec_t;

  exp_t sb_q[$];
  exp_t cur_exp;
  int   checks = 0;
  int   failures = 0;
  logic obs_steal;

  logic          m_gate  [NV];
  logic [NW-1:0] m_note  [NV];
  logic [PW-1:0] m_pitch [NV];
  int            m_age   [NV];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int v = 0; v < NV; v++) begin
      m_gate[v] = 1'b0; m_note[v] = '0; m_pitch[v] = '0; m_age[v] = 0;
    end
  endtask

  task automatic model_panic();
    for (int v = 0; v < NV; v++) begin
      m_gate[v] = 1'b0; m_age[v] = 0;
    end
  endtask

  function automatic exp_t model_snapshot();
    exp_t e;
    e.pitch = '0; e.note = '0; e.gate = '0; e.steal = 1'b0;
    for (int v = 0; v < NV; v++) begin
      e.pitch[v*PW +: PW] = m_pitch[v];
      e.note[v*NW +: NW]  = m_note[v];
      e.gate[v]           = m_gate[v];
    end
    return e;
  endfunction

  task automatic model_event(input logic on, input logic [NW-1:0] note,
                             input logic [PW-1:0] pitch, output logic steal);
    int tgt;
    tgt = -1;
    steal = 1'b0;
    if (on) begin
      for (int v = 0; v < NV; v++) if (m_gate[v] && m_note[v] == note) tgt = v;
      if (tgt < 0) for (int v = 0; v < NV; v++) if (!m_gate[v] && tgt < 0) tgt = v;
      if (tgt < 0) begin
        tgt = 0;
        for (int v = 1; v < NV; v++) if (m_age[v] > m_age[tgt]) tgt = v;
        steal = 1'b1;
      end
      for (int v = 0; v < NV; v++) begin
        if (v == tgt) begin
          m_gate[v] = 1'b1; m_note[v] = note; m_pitch[v] = pitch; m_age[v] = 0;
        end else if (m_gate[v] && m_age[v] < AGE_MAX) begin
          m_age[v]++;
        end
      end
    end else begin
      for (int v = 0; v < NV; v++) if (m_gate[v] && m_note[v] == note) m_gate[v] = 1'b0;
    end
  endtask

  task automatic chk_outs(input string tag, input exp_t e);
    chk({tag, "_gate"},  voice_gate,  e.gate);
    chk({tag, "_pitch"}, voice_pitch, e.pitch);
    chk({tag, "_note"},  voice_note,  e.note);
    chk({tag, "_steal"}, steal_pulse, e.steal);
  endtask

  task automatic do_reset();
    ev_valid = 1'b0; panic = 1'b0;
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    model_reset();
    sb_q.delete();
    cur_exp = model_snapshot();
  endtask

  task automatic accept_only(input logic on, input logic [NW-1:0] note, input logic [PW-1:0] pitch);
    int waited;
    waited = 0;
    ev_valid = 1'b1; ev_on = on; ev_note = note; ev_pitch = pitch;
    while (ev_ready !== 1'b1 && waited < 20) begin @(posedge clk); #1; waited++; end
    chk("accept_ready", ev_ready, 1'b1);
    @(posedge clk); #1;
    ev_valid = 1'b0; ev_pitch = ~pitch;
  endtask

  task automatic send_event(input logic on, input logic [NW-1:0] note, input logic [PW-1:0] pitch);
    exp_t e;
    logic st;
    int   waited;
    waited = 0;
    ev_valid = 1'b1; ev_on = on; ev_note = note; ev_pitch = pitch;
    while (ev_ready !== 1'b1 && waited < 20) begin @(posedge clk); #1; waited++; end
    chk("ready_idle", ev_ready, 1'b1);
    @(posedge clk); #1;
    ev_valid = 1'b0; ev_on = ~on; ev_note = note ^ 7'd1; ev_pitch = ~pitch;
    model_event(on, note, pitch, st);
    e = model_snapshot();
    e.steal = st;
    sb_q.push_back(e);
    for (int k = 0; k <= NV; k++) begin
      chk("ready_busy", ev_ready, 1'b0);
      chk_outs("hold", cur_exp);
      @(posedge clk); #1;
    end
    if (sb_q.size() == 0) begin
      checks++; failures++;
      $display("FAIL scoreboard_empty actual=0 required=1");
    end else begin
      e = sb_q.pop_front();
      chk_outs("commit", e);
      chk("ready_back", ev_ready, 1'b1);
      obs_steal = steal_pulse;
      cur_exp = e;
      cur_exp.steal = 1'b0;
    end
    @(posedge clk); #1;
    chk("steal_clear", steal_pulse, 1'b0);
  endtask

  vec_t tbl[15];

  initial begin
    tbl[0]  = '{1'b1, 1'b1, 7'd60, 16'h1234, 4'b0001, 1'b0, 16'h1234};
    tbl[1]  = '{1'b1, 1'b1, 7'd60, 16'h1000, 4'b0001, 1'b0, 16'h1000};
    tbl[2]  = '{1'b0, 1'b1, 7'd62, 16'h1100, 4'b0011, 1'b0, 16'h1000};
    tbl[3]  = '{1'b0, 1'b1, 7'd64, 16'h1200, 4'b0111, 1'b0, 16'h1000};
    tbl[4]  = '{1'b0, 1'b1, 7'd65, 16'h1300, 4'b1111, 1'b0, 16'h1000};
    tbl[5]  = '{1'b0, 1'b1, 7'd67, 16'h1700, 4'b1111, 1'b1, 16'h1700};
    tbl[6]  = '{1'b1, 1'b1, 7'd60, 16'h2000, 4'b0001, 1'b0, 16'h2000};
    tbl[7]  = '{1'b0, 1'b1, 7'd62, 16'h2100, 4'b0011, 1'b0, 16'h2000};
    tbl[8]  = '{1'b0, 1'b0, 7'd60, 16'h0000, 4'b0010, 1'b0, 16'h2000};
    tbl[9]  = '{1'b0, 1'b1, 7'd69, 16'h2200, 4'b0011, 1'b0, 16'h2200};
    tbl[10] = '{1'b1, 1'b1, 7'd60, 16'h3000, 4'b0001, 1'b0, 16'h3000};
    tbl[11] = '{1'b0, 1'b1, 7'd60, 16'h3100, 4'b0001, 1'b0, 16'h3100};
    tbl[12] = '{1'b0, 1'b0, 7'd61, 16'h0000, 4'b0001, 1'b0, 16'h3100};
    tbl[13] = '{1'b0, 1'b1, 7'd40, 16'h3300, 4'b0011, 1'b0, 16'h3100};
    tbl[14] = '{1'b0, 1'b0, 7'd40, 16'h0000, 4'b0001, 1'b0, 16'h3100};

    resetn = 1'b1; ev_valid = 1'b0; ev_on = 1'b0; ev_note = '0; ev_pitch = '0; panic = 1'b0;
    #2 resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_gate", voice_gate, '0);
    chk("rst_pitch", voice_pitch, '0);
    chk("rst_note", voice_note, '0);
    chk("rst_steal", steal_pulse, 1'b0);
    resetn = 1'b1;
    model_reset();
    cur_exp = model_snapshot();
    chk("rst_ready_after", ev_ready, 1'b1);

    for (int i = 0; i < 15; i++) begin
      if (tbl[i].rst_before) do_reset();
      send_event(tbl[i].on, tbl[i].note, tbl[i].pitch);
      chk($sformatf("tbl%0d_gate", i), voice_gate, tbl[i].exp_gate);
      chk($sformatf("tbl%0d_steal", i), obs_steal, tbl[i].exp_steal);
      chk($sformatf("tbl%0d_p0", i), voice_pitch[PW-1:0], tbl[i].exp_p0);
    end

    // Panic while a note-on is scanning with two voices gated.
    do_reset();
    send_event(1'b1, 7'd60, 16'h4000);
    send_event(1'b1, 7'd62, 16'h4100);
    accept_only(1'b1, 7'd64, 16'h4200);
    @(posedge clk); #1;
    panic = 1'b1; ev_valid = 1'b1; ev_on = 1'b1; ev_note = 7'd70; ev_pitch = 16'h4444;
    chk("panic_ready_scan", ev_ready, 1'b0);
    @(posedge clk); #1;
    model_panic();
    cur_exp = model_snapshot();
    chk_outs("panic", cur_exp);
    chk("panic_ready_idle", ev_ready, 1'b0);
    chk("panic_gate_hand", voice_gate, 4'b0000);
    panic = 1'b0; ev_valid = 1'b0;
    repeat (NV + 3) @(posedge clk);
    #1;
    chk_outs("post_panic", cur_exp);
    chk("panic_p1_held", voice_pitch[2*PW-1:PW], 16'h4100);
    send_event(1'b1, 7'd71, 16'h4300);
    chk("after_panic_gate", voice_gate, 4'b0001);

    // Reset asserted in the middle of a scan.
    do_reset();
    send_event(1'b1, 7'd60, 16'h5000);
    accept_only(1'b1, 7'd62, 16'h5100);
    @(posedge clk); #1;
    resetn = 1'b0;
    #1;
    chk("midrst_gate", voice_gate, '0);
    chk("midrst_pitch", voice_pitch, '0);
    chk("midrst_note", voice_note, '0);
    @(posedge clk); #1;
    resetn = 1'b1;
    model_reset();
    cur_exp = model_snapshot();
    chk("midrst_ready", ev_ready, 1'b1);
    repeat (NV + 3) @(posedge clk);
    #1;
    chk_outs("midrst_quiet", cur_exp);
    send_event(1'b1, 7'd50, 16'h5200);
    chk("midrst_v0_note", voice_note[NW-1:0], 7'd50);
    chk("midrst_v0_gate", voice_gate, 4'b0001);

    // Age saturation: voice0 must stay oldest even after 256+ increments.
    do_reset();
    send_event(1'b1, 7'd60, 16'h6000);
    send_event(1'b1, 7'd62, 16'h6100);
    for (int r = 0; r < 253; r++) send_event(1'b1, 7'd62, 16'h6100 + 16'(r));
    send_event(1'b1, 7'd64, 16'h6200);
    send_event(1'b1, 7'd65, 16'h6300);
    send_event(1'b1, 7'd67, 16'h6700);
    chk("sat_steal", obs_steal, 1'b1);
    chk("sat_v0_note", voice_note[NW-1:0], 7'd67);
    chk("sat_v1_note", voice_note[2*NW-1:NW], 7'd62);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
